// File: rtl/mips_hazard_scheduler_if.sv
// Hazard scheduler <-> core signal bundle.
// master = core side, slave = scheduler side.
interface mips_hazard_scheduler_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic              id_src1_used;
  logic [REG_AW-1:0] id_src2;
  logic              id_src2_used;
  logic [REG_AW-1:0] id_dest;
  logic              id_dest_wr;
  logic              id_is_load;
  logic              id_is_halt;
  logic              ex_branch_taken;
  logic              stall_if;
  logic              bubble_ex;
  logic              flush;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              halt_seen;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_src1, id_src1_used,
    output id_src2, id_src2_used, id_dest,
    output id_dest_wr, id_is_load, id_is_halt,
    output ex_branch_taken,
    input  stall_if, bubble_ex, flush,
    input  fwd_a_sel, fwd_b_sel, halt_seen,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src1_used,
    input  id_src2, id_src2_used, id_dest,
    input  id_dest_wr, id_is_load, id_is_halt,
    input  ex_branch_taken,
    output stall_if, bubble_ex, flush,
    output fwd_a_sel, fwd_b_sel, halt_seen,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/mips_hazard_scheduler.sv
// MIPS-lite hazard/flow controller: shadow EX/MEM/WB scoreboard, stall, flush, halt drain.
// Build macro FORWARDING_EN: load-use-only hazards plus EX operand forwarding selects.
module mips_hazard_scheduler #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 32
) (
  input logic CLOCK,
  input logic RESET_N,
  mips_hazard_scheduler_if.slave bus
);

  if ($clog2(NUM_REGS) != REG_AW) begin : g_bad_cfg
    $error("REG_AW must equal clog2(NUM_REGS)");
  end

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              dest_wr;
    logic              is_load;
    logic              is_halt;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
  } ent_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } halt_st_t;

  ent_t             r_ex;
  ent_t             r_mem;
  ent_t             r_wb;
  ent_t             w_id;
  halt_st_t         r_hst;
  halt_st_t         w_hst_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_raw;
  logic             w_flush;
  logic             w_hz_stall;
  logic             w_halt_hold;
  logic             w_stall;
  logic             w_issue;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_unused;

  function automatic logic hit(
    input ent_t              e,
    input logic [REG_AW-1:0] s,
    input logic              u
  );
    return u & e.valid & e.dest_wr & (e.dest == s);
  endfunction

`ifdef FORWARDING_EN
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] s,
    input ent_t              m,
    input ent_t              w
  );
    logic [1:0] sel;
    sel = 2'b00;
    unique case (1'b1)
      hit(m, s, 1'b1): sel = 2'b01;
      hit(w, s, 1'b1): sel = 2'b10;
      default:         sel = 2'b00;
    endcase
    return sel;
  endfunction
`endif

  assign w_id.valid   = 1'b1;
  assign w_id.dest    = bus.id_dest;
  assign w_id.dest_wr = bus.id_dest_wr;
  assign w_id.is_load = bus.id_is_load;
  assign w_id.is_halt = bus.id_is_halt;
  assign w_id.src1    = bus.id_src1;
  assign w_id.src2    = bus.id_src2;

  // RAW detection against in-flight producers, and EX operand source selects
  always_comb begin
    w_raw   = 1'b0;
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
`ifdef FORWARDING_EN
    w_raw = r_ex.is_load
          & (hit(r_ex, bus.id_src1, bus.id_src1_used)
           | hit(r_ex, bus.id_src2, bus.id_src2_used));
    if (r_ex.valid) begin
      w_fwd_a = fwd_sel(r_ex.src1, r_mem, r_wb);
      w_fwd_b = fwd_sel(r_ex.src2, r_mem, r_wb);
    end
`else
    w_raw = hit(r_ex,  bus.id_src1, bus.id_src1_used)
          | hit(r_ex,  bus.id_src2, bus.id_src2_used)
          | hit(r_mem, bus.id_src1, bus.id_src1_used)
          | hit(r_mem, bus.id_src2, bus.id_src2_used);
`endif
  end

  assign w_flush     = RESET_N & bus.ex_branch_taken;
  assign w_halt_hold = RESET_N & (r_hst != S_RUN);
  assign w_hz_stall  = RESET_N & bus.id_valid & w_raw & ~w_flush;
  assign w_stall     = w_hz_stall | w_halt_hold;
  assign w_issue     = bus.id_valid & ~w_stall & ~w_flush;

  assign bus.stall_if  = w_stall;
  assign bus.bubble_ex = w_stall;
  assign bus.flush     = w_flush;
  assign bus.fwd_a_sel = RESET_N ? w_fwd_a : 2'b00;
  assign bus.fwd_b_sel = RESET_N ? w_fwd_b : 2'b00;
  assign bus.halt_seen = RESET_N & (r_hst == S_DONE);
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

  // Shadow pipeline: ID issues into EX or a bubble is inserted
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex  <= w_issue ? w_id : '0;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  // Halt state register
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) r_hst <= S_RUN;
    else          r_hst <= w_hst_nxt;
  end

  // Halt drain: issued HALT freezes issue, done once it has sat in WB
  always_comb begin
    w_hst_nxt = r_hst;
    unique case (r_hst)
      S_RUN:   if (w_issue & bus.id_is_halt) w_hst_nxt = S_DRAIN;
      S_DRAIN: if (r_wb.valid & r_wb.is_halt) w_hst_nxt = S_DONE;
      S_DONE:  w_hst_nxt = S_DONE;
      default: w_hst_nxt = S_RUN;
    endcase
  end

  // Saturating stall/flush statistics; halt-hold cycles are not hazards
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_hz_stall && !w_halt_hold && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign w_unused = ^{r_ex, r_mem, r_wb};

endmodule

// File: tb/tb_mips_hazard_scheduler.sv
// Scoreboard bench for mips_hazard_scheduler (CNT_W=4 to reach saturation quickly).
// Expected outputs are queued as stimulus is driven and checked on the falling edge.
module tb_mips_hazard_scheduler;
  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    bit       rst;
    bit       v;
    bit [4:0] s1;
    bit       u1;
    bit [4:0] s2;
    bit       u2;
    bit [4:0] d;
    bit       w;
    bit       ld;
    bit       ht;
    bit       br;
  } stim_t;

  typedef struct {
    bit       rst;
    bit       hz;
    bit       hl;
    bit       fl;
    bit [1:0] fa;
    bit [1:0] fb;
    bit       hs;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  exp_t  sb[$];
  exp_t  m_x;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    m_scnt = 0;
  int    m_fcnt = 0;
  int    cyc = 0;
  string tag = "init";

  always #5 clk = ~clk;

  mips_hazard_scheduler_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  mips_hazard_scheduler #(
    .NUM_REGS(32),
    .REG_AW(AW),
    .CNT_W(CW)
  ) dut (
    .CLOCK(clk),
    .RESET_N(rst_n),
    .bus(bus)
  );

  function automatic stim_t ins(
    input bit [4:0] s1, input bit u1,
    input bit [4:0] s2, input bit u2,
    input bit [4:0] d,  input bit w,
    input bit ld, input bit ht
  );
    stim_t s;
    s = '{default: 0};
    s.v = 1; s.s1 = s1; s.u1 = u1;
    s.s2 = s2; s.u2 = u2; s.d = d;
    s.w = w; s.ld = ld; s.ht = ht;
    return s;
  endfunction

  function automatic exp_t ex(
    input bit hz, input bit hl, input bit fl,
    input bit [1:0] fa, input bit [1:0] fb, input bit hs
  );
    exp_t e;
    e = '{default: 0};
    e.hz = hz; e.hl = hl; e.fl = fl;
    e.fa = fa; e.fb = fb; e.hs = hs;
    return e;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic step(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst_n               = !s.rst;
    bus.id_valid        = s.v;
    bus.id_src1         = s.s1;
    bus.id_src1_used    = s.u1;
    bus.id_src2         = s.s2;
    bus.id_src2_used    = s.u2;
    bus.id_dest         = s.d;
    bus.id_dest_wr      = s.w;
    bus.id_is_load      = s.ld;
    bus.id_is_halt      = s.ht;
    bus.ex_branch_taken = s.br;
    cyc++;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    stim_t s;
    exp_t  e;
    s = nop(); s.rst = 1;
    e = ex(0, 0, 0, 2'b00, 2'b00, 0); e.rst = 1;
    step(s, e);
  endtask

  // Scoreboard: one expected record per driven cycle
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      m_x = sb.pop_front();
      n_cmp++;
      if (bus.stall_if !== (m_x.hz | m_x.hl)) begin
        n_bad++;
        $display("FAIL %s c%0d stall_if got %b want %b", tag, cyc, bus.stall_if, m_x.hz | m_x.hl);
      end
      n_cmp++;
      if (bus.bubble_ex !== (m_x.hz | m_x.hl)) begin
        n_bad++;
        $display("FAIL %s c%0d bubble_ex got %b want %b", tag, cyc, bus.bubble_ex, m_x.hz | m_x.hl);
      end
      n_cmp++;
      if (bus.flush !== m_x.fl) begin
        n_bad++;
        $display("FAIL %s c%0d flush got %b want %b", tag, cyc, bus.flush, m_x.fl);
      end
      n_cmp++;
      if (bus.fwd_a_sel !== m_x.fa) begin
        n_bad++;
        $display("FAIL %s c%0d fwd_a_sel got %b want %b", tag, cyc, bus.fwd_a_sel, m_x.fa);
      end
      n_cmp++;
      if (bus.fwd_b_sel !== m_x.fb) begin
        n_bad++;
        $display("FAIL %s c%0d fwd_b_sel got %b want %b", tag, cyc, bus.fwd_b_sel, m_x.fb);
      end
      n_cmp++;
      if (bus.halt_seen !== m_x.hs) begin
        n_bad++;
        $display("FAIL %s c%0d halt_seen got %b want %b", tag, cyc, bus.halt_seen, m_x.hs);
      end
      n_cmp++;
      if (bus.stall_cnt !== CW'(m_scnt)) begin
        n_bad++;
        $display("FAIL %s c%0d stall_cnt got %0d want %0d", tag, cyc, bus.stall_cnt, m_scnt);
      end
      n_cmp++;
      if (bus.flush_cnt !== CW'(m_fcnt)) begin
        n_bad++;
        $display("FAIL %s c%0d flush_cnt got %0d want %0d", tag, cyc, bus.flush_cnt, m_fcnt);
      end
      if (m_x.rst) begin
        m_scnt = 0;
        m_fcnt = 0;
      end else begin
        if (m_x.hz && m_scnt < CMAX) m_scnt++;
        if (m_x.fl && m_fcnt < CMAX) m_fcnt++;
      end
    end
  end

  task automatic test_reset();
    stim_t s;
    exp_t  e;
    tag = "reset";
    s = ins(5'd1, 1, 5'd2, 1, 5'd3, 1, 1, 0);
    s.rst = 1; s.br = 1;
    e = ex(0, 0, 0, 2'b00, 2'b00, 0); e.rst = 1;
    step(s, e);
    step(s, e);
    step(ins(5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 0), ex(0, 0, 0, 2'b00, 2'b00, 0));
    step(nop(), ex(0, 0, 0, 2'b00, 2'b00, 0));
    n_cmp++;
    if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_raw();
    stim_t a;
    stim_t b;
    tag = "raw";
    do_reset();
    a = ins(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0);
    b = ins(5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 0);
`ifdef FORWARDING_EN
    step(a, ex(0, 0, 0, 2'b00, 2'b00, 0));
    step(b, ex(0, 0, 0, 2'b00, 2'b00, 0));
    step(nop(), ex(0, 0, 0, 2'b01, 2'b00, 0));
    n_cmp++;
    if (bus.stall_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL raw_cnt got %0d want 0", bus.stall_cnt);
    end
`else
    step(a, ex(0, 0, 0, 2'b00, 2'b00, 0));
    step(b, ex(1, 0, 0, 2'b00, 2'b00, 0));
    step(b, ex(1, 0, 0, 2'b00, 2'b00, 0));
    step(b, ex(0, 0, 0, 2'b00, 2'b00, 0));
    step(nop(), ex(0, 0, 0, 2'b00, 2'b00, 0));
    n_cmp++;
    if (bus.stall_cnt !== 4'd2) begin
      n_bad++;
      $display("FAIL raw_cnt got %0d want 2", bus.stall_cnt);
    end
`endif
  endtask

  task automatic test_load_use();
    stim_t l;
    stim_t a;
    tag = "load_use";
    do_reset();
    l = ins(5'd1, 1, 5'd2, 0, 5'd2, 1, 1, 0);
    a = ins(5'd2, 1, 5'd2, 1, 5'd4, 1, 0, 0);
    step(l, ex(0, 0, 0, 2'b00, 2'b00, 0));
    step(a, ex(1, 0, 0, 2'b00, 2'b00, 0));
`ifdef FORWARDING_EN
    step(a, ex(0, 0, 0, 2'b00, 2'b00, 0));
    step(nop(), ex(0, 0, 0, 2'b10, 2'b10, 0));
    n_cmp++;
    if (bus.stall_cnt !== 4'd1) begin
      n_bad++;
      $display("FAIL load_use_cnt got %0d want 1", bus.stall_cnt);
    end
`else
    step(a, ex(1, 0, 0, 2'b00, 2'b00, 0));
    step(a, ex(0, 0, 0, 2'b00, 2'b00, 0));
    step(nop(), ex(0, 0, 0, 2'b00, 2'b00, 0));
    n_cmp++;
    if (bus.stall_cnt !== 4'd2) begin
      n_bad++;
      $display("FAIL load_use_cnt got %0d want 2", bus.stall_cnt);
    end
`endif
  endtask

  task automatic test_flush();
    stim_t v;
    tag = "flush";
    do_reset();
    step(ins(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0), ex(0, 0, 0, 2'b00, 2'b00, 0));
    step(ins(5'd7, 1, 5'd8, 1, 5'd0, 0, 0, 0), ex(0, 0, 0, 2'b00, 2'b00, 0));
    v = ins(5'd3, 1, 5'd0, 0, 5'd5, 1, 1, 0);
    v.br = 1;
    step(v, ex(0, 0, 1, 2'b00, 2'b00, 0));
    step(ins(5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0), ex(0, 0, 0, 2'b00, 2'b00, 0));
    step(nop(), ex(0, 0, 0, 2'b00, 2'b00, 0));
    n_cmp++;
    if (bus.flush_cnt !== 4'd1 || bus.stall_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL flush_cnts got %0d/%0d want 1/0", bus.flush_cnt, bus.stall_cnt);
    end
  endtask

  task automatic test_halt();
    stim_t o;
    tag = "halt";
    do_reset();
    o = ins(5'd9, 1, 5'd10, 1, 5'd11, 1, 0, 0);
    step(ins(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1), ex(0, 0, 0, 2'b00, 2'b00, 0));
    for (int k = 1; k <= 9; k++)
      step(o, ex(0, 1, 0, 2'b00, 2'b00, k >= 4));
    n_cmp++;
    if (bus.halt_seen !== 1'b1 || bus.stall_if !== 1'b1 || bus.stall_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL halt_end got seen=%b stall=%b cnt=%0d want 1/1/0",
               bus.halt_seen, bus.stall_if, bus.stall_cnt);
    end
  endtask

  task automatic test_halt_flushed();
    stim_t h;
    tag = "halt_flushed";
    do_reset();
    h = ins(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
    h.br = 1;
    step(h, ex(0, 0, 1, 2'b00, 2'b00, 0));
    for (int k = 1; k <= 6; k++)
      step(nop(), ex(0, 0, 0, 2'b00, 2'b00, 0));
    n_cmp++;
    if (bus.halt_seen !== 1'b0 || bus.flush_cnt !== 4'd1) begin
      n_bad++;
      $display("FAIL halt_flushed_end got seen=%b fcnt=%0d want 0/1",
               bus.halt_seen, bus.flush_cnt);
    end
  endtask

  task automatic test_back_to_back();
    stim_t c;
    bit    hz;
    bit [1:0] fa;
    tag = "back_to_back";
    do_reset();
    c = ins(5'd1, 1, 5'd0, 0, 5'd1, 1, 1, 0);
    for (int k = 0; k < 45; k++) begin
      hz = FWD ? (k % 2 == 1) : (k % 3 != 0);
      fa = (FWD && k % 2 == 1 && k >= 3) ? 2'b10 : 2'b00;
      step(c, ex(hz, 0, 0, fa, 2'b00, 0));
    end
    step(nop(), ex(0, 0, 0, 2'b00, 2'b00, 0));
    n_cmp++;
    if (bus.stall_cnt !== 4'd15) begin
      n_bad++;
      $display("FAIL sat_cnt got %0d want 15", bus.stall_cnt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n               = 1'b0;
    bus.id_valid        = 1'b0;
    bus.id_src1         = '0;
    bus.id_src1_used    = 1'b0;
    bus.id_src2         = '0;
    bus.id_src2_used    = 1'b0;
    bus.id_dest         = '0;
    bus.id_dest_wr      = 1'b0;
    bus.id_is_load      = 1'b0;
    bus.id_is_halt      = 1'b0;
    bus.ex_branch_taken = 1'b0;
    test_reset();
    test_raw();
    test_load_use();
    test_flush();
    test_halt();
    test_halt_flushed();
    test_back_to_back();
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
